// File: rtl/uart_switch_n.sv
// uart_switch_n: routes one host UART to one of NCH target UARTs.
// The channel select is synchronised and debounced, and a switch waits for an idle link plus a dead gap.
module uart_switch_n #(
  parameter int NCH         = 4,
  parameter int SEL_W       = 2,
  parameter int RESET_CH    = 0,
  parameter int DEBOUNCE    = 16,
  parameter int IDLE_CYCLES = 1000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             host_txd_i,
  output logic             host_rxd_o,
  output logic [NCH-1:0]   ch_txd_o,
  output logic [NCH-1:0]   ch_txd_oe,
  input  logic [NCH-1:0]   ch_rxd_i,
  output logic [NCH-1:0]   led_o,
  output logic [SEL_W-1:0] active_o,
  output logic             switching_o
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [DW-1:0]    DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [IW-1:0]    IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] RST_SEL  = SEL_W'(RESET_CH);
  localparam logic [SEL_W:0]   NCH_LIM  = (SEL_W + 1)'(NCH);
  localparam logic [NCH-1:0]   RST_LED  = NCH'(1) << RESET_CH;

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    GAP
  } state_t;

  state_t state;
  state_t state_n;

  logic [SEL_W-1:0] sel_s1;
  logic [SEL_W-1:0] sel_s2;
  logic [SEL_W-1:0] sel_prev;
  logic [SEL_W-1:0] req_sel;
  logic [DW-1:0]    deb_cnt;

  logic             txd_s1;
  logic             txd_s2;
  logic             rxd_s1;
  logic             rxd_s2;
  logic             act_rxd;
  logic [IW-1:0]    idle_cnt;

  logic [SEL_W-1:0] active;
  logic [SEL_W-1:0] target;
  logic [GW-1:0]    gap_cnt;
  logic [NCH-1:0]   led;

  logic req_ok;
  logic idle_ok;
  logic gap_done;
  logic drain_entry;

  assign req_ok      = {1'b0, req_sel} < NCH_LIM;
  assign idle_ok     = idle_cnt == IDLE_MAX;
  assign gap_done    = gap_cnt == GAP_LAST;
  assign drain_entry = (state == ACTIVE) && (state_n == DRAIN);

  // Select synchroniser; a value is accepted once stable for DEBOUNCE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_s1   <= RST_SEL;
      sel_s2   <= RST_SEL;
      sel_prev <= RST_SEL;
      req_sel  <= RST_SEL;
      deb_cnt  <= '0;
    end else begin
      sel_s1   <= sel_i;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
      if (sel_s2 != sel_prev) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
      end else begin
        req_sel <= sel_s2;
      end
    end
  end

  // Idle detector: counts cycles where both directions sit at mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd_s1   <= 1'b1;
      txd_s2   <= 1'b1;
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      idle_cnt <= '0;
    end else begin
      txd_s1 <= host_txd_i;
      txd_s2 <= txd_s1;
      rxd_s1 <= act_rxd;
      rxd_s2 <= rxd_s1;
      if (drain_entry || !(txd_s2 && rxd_s2)) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // Switch sequencer next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      ACTIVE: begin
        if (req_ok && (req_sel != active)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!req_ok || (req_sel == active)) begin
          state_n = ACTIVE;
        end else if (idle_ok) begin
          state_n = GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_n = ACTIVE;
        end
      end
      default: state_n = ACTIVE;
    endcase
  end

  // State register plus target latch, gap timer and active-channel update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACTIVE;
      active  <= RST_SEL;
      target  <= RST_SEL;
      gap_cnt <= '0;
      led     <= RST_LED;
    end else begin
      state <= state_n;
      if ((state == DRAIN) && req_ok) begin
        target <= req_sel;
      end
      if ((state != GAP) && (state_n == GAP)) begin
        gap_cnt <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if ((state == GAP) && gap_done) begin
        active <= target;
        led    <= NCH'(1) << target;
      end
    end
  end

  // Routing: active channel gets the host, everything parks at mark during GAP.
  always_comb begin
    ch_txd_o   = '1;
    ch_txd_oe  = '0;
    host_rxd_o = 1'b1;
    act_rxd    = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (active == SEL_W'(i)) begin
        act_rxd = ch_rxd_i[i];
        if (state != GAP) begin
          ch_txd_o[i]  = host_txd_i;
          ch_txd_oe[i] = 1'b1;
          host_rxd_o   = ch_rxd_i[i];
        end
      end
    end
  end

  assign led_o       = led;
  assign active_o    = active;
  assign switching_o = state != ACTIVE;

endmodule

// File: tb/tb_uart_switch_n.sv
// tb_uart_switch_n: random select/line traffic against a history-based model.
// Two instances: 4 channels, and 3 channels so select value 3 is out of range.
module tb_uart_switch_n;

  localparam int DEB  = 4;
  localparam int IDL  = 8;
  localparam int GP   = 2;
  localparam int MAXK = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic       host_txd = 1'b1;
  logic [3:0] ch_rxd = 4'hF;

  logic       hrx0;
  logic [3:0] tx0;
  logic [3:0] oe0;
  logic [3:0] led0;
  logic [1:0] act0;
  logic       sw0;

  logic       hrx1;
  logic [2:0] tx1;
  logic [2:0] oe1;
  logic [2:0] led1;
  logic [1:0] act1;
  logic       sw1;

  always #5 clk = ~clk;

  uart_switch_n #(
    .NCH(4), .SEL_W(2), .RESET_CH(0),
    .DEBOUNCE(DEB), .IDLE_CYCLES(IDL), .GAP_CYCLES(GP)
  ) u0 (
    .clk(clk), .rst(rst), .sel_i(sel),
    .host_txd_i(host_txd), .host_rxd_o(hrx0),
    .ch_txd_o(tx0), .ch_txd_oe(oe0), .ch_rxd_i(ch_rxd),
    .led_o(led0), .active_o(act0), .switching_o(sw0)
  );

  uart_switch_n #(
    .NCH(3), .SEL_W(2), .RESET_CH(0),
    .DEBOUNCE(DEB), .IDLE_CYCLES(IDL), .GAP_CYCLES(GP)
  ) u1 (
    .clk(clk), .rst(rst), .sel_i(sel),
    .host_txd_i(host_txd), .host_rxd_o(hrx1),
    .ch_txd_o(tx1), .ch_txd_oe(oe1), .ch_rxd_i(ch_rxd[2:0]),
    .led_o(led1), .active_o(act1), .switching_o(sw1)
  );

  typedef struct packed {
    logic [1:0] act;
    logic [3:0] led;
    logic [3:0] oe;
    logic [3:0] tx;
    logic       sw;
    logic       hr;
  } dexp_t;

  typedef struct packed {
    dexp_t d1;
    dexp_t d0;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit done = 0;

  // model: 0 = routing, 1 = waiting for idle, 2 = dead gap
  int k = 0;
  int last_rst = 0;
  int sh[MAXK+1];
  bit th[MAXK+1];
  bit rh[2][MAXK+1];
  int nch[2] = '{4, 3};
  int m_state[2];
  int m_act[2];
  int m_req[2];
  int m_tgt[2];
  int m_e[2];
  int m_g[2];

  function automatic int s_at(int j);
    if (j <= last_rst) return 0;
    return sh[j];
  endfunction

  // both synchronised lines seen at mark by the counter at edge j
  function automatic bit l_at(int d, int j);
    int q;
    q = j - 2;
    if (q <= last_rst) return 1'b1;
    return th[q] & rh[d][q];
  endfunction

  function automatic bit sel_stable();
    int v;
    v = s_at(k - 2);
    for (int j = k - 3 - DEB; j < k - 2; j++) begin
      if (s_at(j) != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit link_ready(int d);
    if (k - IDL < m_e[d] + 1) return 1'b0;
    for (int j = k - IDL; j < k; j++) begin
      if (!l_at(d, j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic dexp_t mk(int d);
    dexp_t e;
    e.act = 2'(m_act[d]);
    e.led = 4'(1 << m_act[d]);
    e.sw  = m_state[d] != 0;
    e.oe  = 4'h0;
    e.tx  = 4'hF;
    e.hr  = 1'b1;
    if (m_state[d] != 2) begin
      e.oe = 4'(1 << m_act[d]);
      e.tx[m_act[d]] = host_txd;
      e.hr = ch_rxd[m_act[d]];
    end
    return e;
  endfunction

  task automatic model_edge();
    bit ok;
    k++;
    sh[k] = int'(sel);
    th[k] = host_txd;
    for (int d = 0; d < 2; d++) rh[d][k] = ch_rxd[m_act[d]];
    if (rst) begin
      last_rst = k;
      for (int d = 0; d < 2; d++) begin
        m_state[d] = 0;
        m_act[d] = 0;
        m_req[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        ok = m_req[d] < nch[d];
        case (m_state[d])
          0: if (ok && m_req[d] != m_act[d]) begin
               m_state[d] = 1;
               m_e[d] = k;
             end
          1: if (!ok || m_req[d] == m_act[d]) begin
               m_state[d] = 0;
             end else if (link_ready(d)) begin
               m_state[d] = 2;
               m_g[d] = k;
               m_tgt[d] = m_req[d];
             end
          default: if (k == m_g[d] + GP) begin
               m_state[d] = 0;
               m_act[d] = m_tgt[d];
             end
        endcase
      end
      if (sel_stable()) begin
        for (int d = 0; d < 2; d++) m_req[d] = s_at(k - 2);
      end
    end
  endtask

  // one clock: log expectation for current inputs, then advance the model
  task automatic cyc();
    exp_t e;
    if (chk_en) begin
      e.d0 = mk(0);
      e.d1 = mk(1);
      sb.push_back(e);
    end
    @(posedge clk);
    if (k >= MAXK - 1) begin
      $display("FAIL history_overflow k=%0d limit=%0d", k, MAXK);
      $fatal(1);
    end
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] got,
                     input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // monitor: compares DUT outputs mid-cycle against the oldest expectation
  initial begin
    exp_t e;
    wait (chk_en);
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("u0_active", {2'b0, act0}, {2'b0, e.d0.act});
        chk("u0_led", led0, e.d0.led);
        chk("u0_switching", {3'b0, sw0}, {3'b0, e.d0.sw});
        chk("u0_oe", oe0, e.d0.oe);
        chk("u0_txd", tx0, e.d0.tx);
        chk("u0_host_rxd", {3'b0, hrx0}, {3'b0, e.d0.hr});
        chk("u1_active", {2'b0, act1}, {2'b0, e.d1.act});
        chk("u1_led", {1'b0, led1}, e.d1.led);
        chk("u1_switching", {3'b0, sw1}, {3'b0, e.d1.sw});
        chk("u1_oe", {1'b0, oe1}, e.d1.oe);
        chk("u1_txd", {1'b1, tx1}, e.d1.tx);
        chk("u1_host_rxd", {3'b0, hrx1}, {3'b0, e.d1.hr});
      end else if (!done) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_empty t=%0t got=0 want=1", $time);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      host_txd = fr[i];
      repeat (3) cyc();
    end
    host_txd = 1'b1;
  endtask

  initial begin
    int hold;
    int mode;
    int n;
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0;
      m_act[d] = 0;
      m_req[d] = 0;
      m_tgt[d] = 0;
      m_e[d] = 0;
      m_g[d] = 0;
    end
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      host_txd = i[0];
      cyc();
    end
    host_txd = 1'b1;

    sel = 2'd2;
    repeat (30) cyc();
    for (int i = 0; i < 4; i++) begin
      ch_rxd[2] = i[0];
      cyc();
    end
    ch_rxd = 4'hF;

    sel = 2'd1;
    send_byte(8'hA5);
    repeat (20) cyc();

    sel = 2'd3;
    repeat (2) cyc();
    sel = 2'd1;
    repeat (20) cyc();
    sel = 2'd0;
    host_txd = 1'b0;
    repeat (9) cyc();
    sel = 2'd1;
    repeat (9) cyc();
    sel = 2'd0;
    repeat (12) cyc();
    host_txd = 1'b1;
    repeat (20) cyc();

    sel = 2'd3;
    repeat (40) cyc();

    for (int p = 0; p < 80; p++) begin
      sel  = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 40);
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      if (mode == 3) begin
        send_byte(8'($urandom));
      end
      for (int c = 0; c < hold; c++) begin
        if (mode == 1) host_txd = $urandom_range(0, 7) != 0;
        else host_txd = 1'b1;
        if (mode == 2) ch_rxd = 4'($urandom);
        else ch_rxd = 4'hF;
        cyc();
      end
    end
    host_txd = 1'b1;
    ch_rxd = 4'hF;

    sel = 2'((m_act[0] + 1) % 4);
    n = 0;
    while (m_state[0] != 2 && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (m_state[0] != 2) begin
      errors++;
      $display("FAIL gap_timeout got=%0d want=2", m_state[0]);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sel = 2'd0;
    repeat (10) cyc();

    done = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
